// File: rtl/ssd_scan_decoder_if.sv
// Display-bus bundle between a multiplexed 7-segment driver and the scan decoder.
// The master drives the segment/anode lines; the slave (decoder) returns the recovered frame.
interface ssd_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          SSD;
  logic [DIGITS-1:0]   AN;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   digit_err;
  logic                frame_valid;

  modport master (
    output SSD,
    output AN,
    input  value,
    input  blank,
    input  digit_err,
    input  frame_valid
  );

  modport slave (
    input  SSD,
    input  AN,
    output value,
    output blank,
    output digit_err,
    output frame_valid
  );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Recovers hex digits from a time-multiplexed active-low 7-segment bus: synchronise,
// wait for a stable digit, decode it, and publish the full frame once every digit is seen.
module ssd_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  ssd_scan_decoder_if.slave bus
);

  localparam logic [7:0]        CNT_LAST = 8'(STABLE_CYC - 1);
  localparam logic [7:0]        CNT_SAT  = 8'(STABLE_CYC);
  localparam logic [DIGITS-1:0] ONE      = DIGITS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_CAPTURED
  } state_t;

  logic [6:0]          ssd_meta_q, ssd_sync_q;
  logic [DIGITS-1:0]   an_meta_q, an_sync_q;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   pair_an_q, pair_an_d;
  logic [6:0]          pair_ssd_q, pair_ssd_d;

  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                fv_q, fv_d;

  logic [3:0]          dec_nib;
  logic                dec_blank;
  logic                dec_err;
  logic [DIGITS-1:0]   sel_onehot;
  logic                sel_valid;
  logic                pair_same;
  logic                capture;

  // Two-flop synchronisers; idle display (all lines high) is the reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssd_meta_q <= '1;
      ssd_sync_q <= '1;
      an_meta_q  <= '1;
      an_sync_q  <= '1;
    end else begin
      ssd_meta_q <= bus.SSD;
      ssd_sync_q <= ssd_meta_q;
      an_meta_q  <= bus.AN;
      an_sync_q  <= an_meta_q;
    end
  end

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (ssd_sync_q)
      7'h40:   dec_nib = 4'h0;
      7'h79:   dec_nib = 4'h1;
      7'h24:   dec_nib = 4'h2;
      7'h30:   dec_nib = 4'h3;
      7'h19:   dec_nib = 4'h4;
      7'h12:   dec_nib = 4'h5;
      7'h02:   dec_nib = 4'h6;
      7'h78:   dec_nib = 4'h7;
      7'h00:   dec_nib = 4'h8;
      7'h18:   dec_nib = 4'h9;
      7'h20:   dec_nib = 4'hA;
      7'h03:   dec_nib = 4'hB;
      7'h46:   dec_nib = 4'hC;
      7'h21:   dec_nib = 4'hD;
      7'h06:   dec_nib = 4'hE;
      7'h0E:   dec_nib = 4'hF;
      7'h7F:   dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // A digit is selected only when exactly one anode is driven low.
  always_comb begin
    sel_onehot = ~an_sync_q;
    sel_valid  = (sel_onehot != '0) && ((sel_onehot & (sel_onehot - ONE)) == '0);
    pair_same  = (an_sync_q == pair_an_q) && (ssd_sync_q == pair_ssd_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pair_an_q  <= '1;
      pair_ssd_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pair_an_q  <= pair_an_d;
      pair_ssd_q <= pair_ssd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pair_an_d  = pair_an_q;
    pair_ssd_d = pair_ssd_q;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d    = S_DWELL;
          cnt_d      = 8'd1;
          pair_an_d  = an_sync_q;
          pair_ssd_d = ssd_sync_q;
        end
      end
      S_DWELL: begin
        if (!sel_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!pair_same) begin
          cnt_d      = 8'd1;
          pair_an_d  = an_sync_q;
          pair_ssd_d = ssd_sync_q;
        end else if (cnt_q == CNT_LAST) begin
          // This sample is the STABLE_CYC-th identical one: capture now.
          capture = 1'b1;
          state_d = S_CAPTURED;
          cnt_d   = CNT_SAT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CAPTURED: begin
        if (!sel_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!pair_same) begin
          state_d    = S_DWELL;
          cnt_d      = 8'd1;
          pair_an_d  = an_sync_q;
          pair_ssd_d = ssd_sync_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val_q   <= '0;
      shadow_blank_q <= '0;
      shadow_err_q   <= '0;
      seen_q         <= '0;
      value_q        <= '0;
      blank_q        <= '0;
      err_q          <= '0;
      fv_q           <= 1'b0;
    end else begin
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_err_q   <= shadow_err_d;
      seen_q         <= seen_d;
      value_q        <= value_d;
      blank_q        <= blank_d;
      err_q          <= err_d;
      fv_q           <= fv_d;
    end
  end

  always_comb begin
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    shadow_err_d   = shadow_err_q;
    seen_d         = seen_q;
    value_d        = value_q;
    blank_d        = blank_q;
    err_d          = err_q;
    fv_d           = 1'b0;
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_onehot[i]) begin
          shadow_val_d[4*i +: 4] = dec_nib;
          shadow_blank_d[i]      = dec_blank;
          shadow_err_d[i]        = dec_err;
          seen_d[i]              = 1'b1;
        end
      end
      // Publishing uses the post-capture shadow so the closing digit is included.
      if (&seen_d) begin
        value_d = shadow_val_d;
        blank_d = shadow_blank_d;
        err_d   = shadow_err_d;
        fv_d    = 1'b1;
        seen_d  = '0;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.blank       = blank_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder (DIGITS=4, STABLE_CYC=4) driving a scanned display bus.
module tb_ssd_scan_decoder;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   fv_count;
  int   last_fv_pos;
  logic [6:0] seg_tab [16];

  ssd_scan_decoder_if #(.DIGITS(4)) bus ();

  ssd_scan_decoder #(
    .DIGITS     (4),
    .STABLE_CYC (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Show one digit for a number of cycles, tallying frame_valid pulses.
  task automatic show_digit(input int idx, input logic [6:0] ssd, input int cycles);
    logic [3:0] an_v;
    an_v      = 4'b1111;
    an_v[idx] = 1'b0;
    bus.AN    = an_v;
    bus.SSD   = ssd;
    $display("[TB] show digit %0d ssd=%02h for %0d cycles", idx, ssd, cycles);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) begin
        fv_count++;
        last_fv_pos = c;
      end
    end
  endtask

  task automatic idle_bus(input logic [3:0] an, input int cycles);
    bus.AN  = an;
    bus.SSD = 7'h7F;
    $display("[TB] drive AN=%b for %0d cycles", an, cycles);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) begin
        fv_count++;
        last_fv_pos = c;
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.AN  = 4'b1111;
    bus.SSD = 7'h7F;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.value !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_value: got %h expected 0000", bus.value);
    end
    tests_run++;
    if (bus.blank !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_blank: got %b expected 0000", bus.blank);
    end
    tests_run++;
    if (bus.digit_err !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_err: got %b expected 0000", bus.digit_err);
    end
    tests_run++;
    if (bus.frame_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fv: got %b expected 0", bus.frame_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_basic_scan();
    int fv0;
    fv0 = fv_count;
    show_digit(0, 7'h19, 10);
    show_digit(1, 7'h30, 10);
    show_digit(2, 7'h24, 10);
    last_fv_pos = 0;
    show_digit(3, 7'h79, 10);
    tests_run++;
    if (fv_count - fv0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_fv_count: got %0d expected 1", fv_count - fv0);
    end
    tests_run++;
    if (last_fv_pos !== 6) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d expected 6", last_fv_pos);
    end
    tests_run++;
    if (bus.value !== 16'h1234) begin
      tests_failed++;
      $display("FAIL basic_value: got %h expected 1234", bus.value);
    end
    tests_run++;
    if (bus.blank !== 4'b0000 || bus.digit_err !== 4'b0000) begin
      tests_failed++;
      $display("FAIL basic_flags: got blank=%b err=%b expected 0000/0000", bus.blank, bus.digit_err);
    end
  endtask

  task automatic test_two_frames();
    int fv0;
    fv0 = fv_count;
    show_digit(0, 7'h20, 10);
    show_digit(1, 7'h03, 10);
    show_digit(2, 7'h46, 10);
    show_digit(3, 7'h21, 10);
    tests_run++;
    if (bus.value !== 16'hDCBA) begin
      tests_failed++;
      $display("FAIL frame1_value: got %h expected DCBA", bus.value);
    end
    show_digit(0, 7'h0E, 10);
    show_digit(1, 7'h06, 10);
    show_digit(2, 7'h02, 10);
    show_digit(3, 7'h00, 10);
    tests_run++;
    if (bus.value !== 16'h86EF) begin
      tests_failed++;
      $display("FAIL frame2_value: got %h expected 86EF", bus.value);
    end
    tests_run++;
    if (fv_count - fv0 !== 2) begin
      tests_failed++;
      $display("FAIL two_frames_fv: got %0d expected 2", fv_count - fv0);
    end
  endtask

  task automatic test_all_codes();
    logic [15:0] exp_val;
    for (int f = 0; f < 4; f++) begin
      exp_val = '0;
      for (int i = 0; i < 4; i++) begin
        show_digit(i, seg_tab[4*f + i], 10);
        exp_val[4*i +: 4] = 4'(4*f + i);
      end
      tests_run++;
      if (bus.value !== exp_val || bus.digit_err !== 4'b0000) begin
        tests_failed++;
        $display("FAIL codes_frame%0d: got value=%h err=%b expected value=%h err=0000",
                 f, bus.value, bus.digit_err, exp_val);
      end
    end
  endtask

  task automatic test_stability();
    int fv0;
    fv0 = fv_count;
    show_digit(0, 7'h79, 3);
    idle_bus(4'b1111, 5);
    show_digit(1, 7'h24, 10);
    show_digit(2, 7'h30, 10);
    show_digit(3, 7'h19, 10);
    tests_run++;
    if (fv_count !== fv0) begin
      tests_failed++;
      $display("FAIL short_dwell_no_capture: got %0d pulses expected 0", fv_count - fv0);
    end
    show_digit(0, 7'h79, 4);
    idle_bus(4'b1111, 5);
    tests_run++;
    if (fv_count - fv0 !== 1 || bus.value !== 16'h4321) begin
      tests_failed++;
      $display("FAIL min_dwell_capture: got pulses=%0d value=%h expected 1/4321",
               fv_count - fv0, bus.value);
    end
    fv0 = fv_count;
    show_digit(0, 7'h12, 50);
    show_digit(1, 7'h24, 10);
    show_digit(2, 7'h30, 10);
    show_digit(3, 7'h78, 50);
    tests_run++;
    if (fv_count - fv0 !== 1 || bus.value !== 16'h7325) begin
      tests_failed++;
      $display("FAIL long_hold_frame: got pulses=%0d value=%h expected 1/7325",
               fv_count - fv0, bus.value);
    end
    show_digit(0, 7'h12, 10);
    show_digit(1, 7'h24, 10);
    show_digit(2, 7'h30, 10);
    tests_run++;
    if (fv_count - fv0 !== 1) begin
      tests_failed++;
      $display("FAIL long_hold_single_capture: got pulses=%0d expected 1", fv_count - fv0);
    end
    show_digit(3, 7'h00, 10);
    tests_run++;
    if (bus.value !== 16'h8325) begin
      tests_failed++;
      $display("FAIL long_hold_next_frame: got %h expected 8325", bus.value);
    end
  endtask

  task automatic test_blank_err();
    int fv0;
    fv0 = fv_count;
    show_digit(0, 7'h40, 10);
    show_digit(1, 7'h40, 10);
    show_digit(2, 7'h7E, 10);
    show_digit(3, 7'h7F, 10);
    tests_run++;
    if (bus.digit_err !== 4'b0100) begin
      tests_failed++;
      $display("FAIL err_flags: got %b expected 0100", bus.digit_err);
    end
    tests_run++;
    if (bus.blank !== 4'b1000) begin
      tests_failed++;
      $display("FAIL blank_flags: got %b expected 1000", bus.blank);
    end
    tests_run++;
    if (bus.value !== 16'h0000 || fv_count - fv0 !== 1) begin
      tests_failed++;
      $display("FAIL blank_err_value: got value=%h pulses=%0d expected 0000/1",
               bus.value, fv_count - fv0);
    end
  endtask

  task automatic test_invalid_select();
    int fv0;
    fv0 = fv_count;
    bus.AN  = 4'b1100;
    bus.SSD = 7'h79;
    $display("[TB] drive AN=1100 ssd=79 for 20 cycles");
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) fv_count++;
    end
    idle_bus(4'b1111, 20);
    tests_run++;
    if (fv_count !== fv0) begin
      tests_failed++;
      $display("FAIL invalid_sel_fv: got %0d pulses expected 0", fv_count - fv0);
    end
    tests_run++;
    if (bus.value !== 16'h0000 || bus.blank !== 4'b1000 || bus.digit_err !== 4'b0100) begin
      tests_failed++;
      $display("FAIL invalid_sel_hold: got value=%h blank=%b err=%b expected 0000/1000/0100",
               bus.value, bus.blank, bus.digit_err);
    end
  endtask

  task automatic test_reset_midframe();
    int fv0;
    show_digit(0, 7'h0E, 10);
    show_digit(1, 7'h0E, 10);
    show_digit(2, 7'h30, 2);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.value !== 16'h0000 || bus.blank !== 4'b0000 ||
        bus.digit_err !== 4'b0000 || bus.frame_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_reset_outputs: got value=%h blank=%b err=%b fv=%b expected all 0",
               bus.value, bus.blank, bus.digit_err, bus.frame_valid);
    end
    rst = 1'b0;
    $display("[TB] mid-frame reset pulse done");
    fv0 = fv_count;
    show_digit(2, 7'h30, 10);
    show_digit(3, 7'h19, 10);
    tests_run++;
    if (fv_count !== fv0) begin
      tests_failed++;
      $display("FAIL midframe_not_retained: got %0d pulses expected 0", fv_count - fv0);
    end
    show_digit(0, 7'h79, 10);
    show_digit(1, 7'h24, 10);
    tests_run++;
    if (fv_count - fv0 !== 1 || bus.value !== 16'h4321) begin
      tests_failed++;
      $display("FAIL midframe_full_scan: got pulses=%0d value=%h expected 1/4321",
               fv_count - fv0, bus.value);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    fv_count     = 0;
    last_fv_pos  = 0;
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h18; seg_tab[10] = 7'h20; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    rst     = 1'b1;
    bus.AN  = 4'b1111;
    bus.SSD = 7'h7F;

    test_reset();
    test_basic_scan();
    test_two_frames();
    test_all_codes();
    test_stability();
    test_blank_err();
    test_invalid_select();
    test_reset_midframe();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
